// File: rtl/count_bcd_display_if.sv
// Bundles the converter's data and display signals between the counter side
// (master) and the BCD display stage (slave).
interface count_bcd_display_if #(
    parameter int WIDTH  = 5,
    parameter int DIGITS = 2
);
    logic [WIDTH-1:0]    bin_in;
    logic [4*DIGITS-1:0] bcd_out;
    logic                bcd_valid;
    logic                busy;
    logic [DIGITS-1:0]   an;
    logic [6:0]          seg;

    modport master (
        output bin_in,
        input  bcd_out, bcd_valid, busy, an, seg
    );

    modport slave (
        input  bin_in,
        output bcd_out, bcd_valid, busy, an, seg
    );
endinterface

// File: rtl/count_bcd_display.sv
// Binary-to-BCD display stage: iterative double-dabble converter feeding a
// time-multiplexed, leading-zero-blanked 7-segment scanner.
module count_bcd_display #(
    parameter int WIDTH    = 5,
    parameter int DIGITS   = 2,
    parameter int SCAN_DIV = 4,
    parameter int BLANK_LZ = 1
) (
    input  logic          clk,
    input  logic          rst,
    count_bcd_display_if.slave bus
);
    localparam int BW     = 4 * DIGITS;
    localparam int STEP_W = $clog2(WIDTH + 1);
    localparam int DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   last_bin_q, last_bin_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [BW-1:0]      scratch_q, scratch_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic               init_q, init_d;
    logic [BW-1:0]      bcd_out_q, bcd_out_d;
    logic               bcd_valid_q, bcd_valid_d;
    logic               busy_q, busy_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DIGITS-1:0]  an_q, an_d;
    logic [6:0]         seg_q, seg_d;

    logic [BW-1:0]      adj;
    logic [6:0]         dig_seg [DIGITS];

    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Add-3 correction applied to every BCD nibble before each shift
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign adj[4*gi +: 4] = (scratch_q[4*gi +: 4] >= 4'd5)
                                  ? scratch_q[4*gi +: 4] + 4'd3
                                  : scratch_q[4*gi +: 4];
        end
    endgenerate

    // Digit k>0 is blank only when it and every higher digit are zero
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_seg
            if (gi == 0 || BLANK_LZ == 0) begin : g_plain
                assign dig_seg[gi] = decode(bcd_out_q[4*gi +: 4]);
            end else begin : g_blank
                assign dig_seg[gi] = (|bcd_out_q[BW-1:4*gi])
                                   ? decode(bcd_out_q[4*gi +: 4]) : 7'h00;
            end
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        last_bin_d  = last_bin_q;
        shreg_d     = shreg_q;
        scratch_d   = scratch_q;
        step_d      = step_q;
        init_d      = init_q;
        bcd_out_d   = bcd_out_q;
        bcd_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (init_q || (bus.bin_in != last_bin_q)) begin
                    last_bin_d = bus.bin_in;
                    shreg_d    = bus.bin_in;
                    scratch_d  = '0;
                    step_d     = '0;
                    init_d     = 1'b0;
                    state_d    = CONV;
                end
            end
            CONV: begin
                scratch_d = {adj[BW-2:0], shreg_q[WIDTH-1]};
                shreg_d   = shreg_q << 1;
                step_d    = step_q + STEP_W'(1);
                if (step_q == STEP_W'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_out_d   = scratch_q;
                bcd_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_comb begin
        div_d = div_q + DIV_W'(1);
        idx_d = idx_q;
        if (div_q == DIV_W'(SCAN_DIV - 1)) begin
            div_d = '0;
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
        an_d        = '0;
        an_d[idx_q] = 1'b1;
        seg_d       = dig_seg[idx_q];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            last_bin_q  <= '0;
            shreg_q     <= '0;
            scratch_q   <= '0;
            step_q      <= '0;
            init_q      <= 1'b1;
            bcd_out_q   <= '0;
            bcd_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            div_q       <= '0;
            idx_q       <= '0;
            an_q        <= '0;
            seg_q       <= '0;
        end else begin
            state_q     <= state_d;
            last_bin_q  <= last_bin_d;
            shreg_q     <= shreg_d;
            scratch_q   <= scratch_d;
            step_q      <= step_d;
            init_q      <= init_d;
            bcd_out_q   <= bcd_out_d;
            bcd_valid_q <= bcd_valid_d;
            busy_q      <= busy_d;
            div_q       <= div_d;
            idx_q       <= idx_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
        end
    end

    assign bus.bcd_out   = bcd_out_q;
    assign bus.bcd_valid = bcd_valid_q;
    assign bus.busy      = busy_q;
    assign bus.an        = an_q;
    assign bus.seg       = seg_q;
endmodule
